// File: rtl/rv64g_pkg.sv
// Shared sizing constants and the decoded-instruction record passed from the decoder.
package rv64g_pkg;
  localparam int NUM_OUTSTANDING = 7;
  localparam int NUM_REGS        = 64;

  typedef struct packed {
    logic [31:0]                 raw;
    logic [$clog2(NUM_REGS)-1:0] rd;
    logic [NUM_REGS-1:0]         reg_req;
    logic                        blocking;
  } decoded_instr_t;
endpackage

// File: rtl/rv64g_instr_launcher_if.sv
// Decoder-in / execute-out / retire signals of the instruction launcher.
interface rv64g_instr_launcher_if #(
  parameter int NUM_OUTSTANDING = rv64g_pkg::NUM_OUTSTANDING,
  parameter int NUM_REGS        = rv64g_pkg::NUM_REGS
);
  rv64g_pkg::decoded_instr_t              instr_in_i;
  logic                                   instr_in_valid_i;
  logic                                   instr_in_ready_o;
  rv64g_pkg::decoded_instr_t              instr_out_o;
  logic                                   instr_out_valid_o;
  logic                                   instr_out_ready_i;
  logic                                   done_valid_i;
  logic [$clog2(NUM_REGS)-1:0]            done_rd_i;
  logic [NUM_REGS-1:0]                    locked_regs_o;
  logic [$clog2(NUM_OUTSTANDING+1)-1:0]   outstanding_o;

  // Launcher side.
  modport slave (
    input  instr_in_i, instr_in_valid_i, instr_out_ready_i, done_valid_i, done_rd_i,
    output instr_in_ready_o, instr_out_o, instr_out_valid_o, locked_regs_o, outstanding_o
  );

  // Decoder / execution-unit side.
  modport master (
    output instr_in_i, instr_in_valid_i, instr_out_ready_i, done_valid_i, done_rd_i,
    input  instr_in_ready_o, instr_out_o, instr_out_valid_o, locked_regs_o, outstanding_o
  );
endinterface

// File: rtl/rv64g_instr_launcher.sv
// Holds decoded instructions until their registers are unlocked, then issues them
// through a one-entry output register; retirements arrive on the done port.
module rv64g_instr_launcher #(
  parameter int NUM_OUTSTANDING = rv64g_pkg::NUM_OUTSTANDING,
  parameter int NUM_REGS        = rv64g_pkg::NUM_REGS
) (
  input logic                    clk_i,
  input logic                    arst_i,
  rv64g_instr_launcher_if.slave  bus
);
  localparam int CW = $clog2(NUM_OUTSTANDING + 1);

  logic [NUM_REGS-1:0]       locks;
  logic [NUM_REGS-1:0]       rd_mask;
  logic [NUM_REGS-1:0]       clr_mask;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_next;
  logic                      blk_pend;
  rv64g_pkg::decoded_instr_t out_q;
  logic                      out_valid;
  logic                      hazard;
  logic                      ready;
  logic                      accept;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holds valid and data stable until that edge.
  always_comb begin
    rd_mask = '0;
    if (bus.instr_in_i.rd != '0) rd_mask[bus.instr_in_i.rd] = 1'b1;
    clr_mask = '0;
    if (bus.done_valid_i && bus.done_rd_i != '0) clr_mask[bus.done_rd_i] = 1'b1;
  end

  assign hazard = |((bus.instr_in_i.reg_req | rd_mask) & locks);
  assign ready  = !arst_i
               && (!out_valid || bus.instr_out_ready_i)
               && !hazard
               && (count < CW'(NUM_OUTSTANDING))
               && !blk_pend
               && (!bus.instr_in_i.blocking || count == '0);
  assign accept = bus.instr_in_valid_i && ready;

  // A done with nothing in flight is ignored for the count (no underflow).
  always_comb begin
    count_next = count;
    if (accept && !bus.done_valid_i)
      count_next = count + CW'(1);
    else if (!accept && bus.done_valid_i && count != '0)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      locks     <= '0;
      count     <= '0;
      blk_pend  <= 1'b0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      locks <= (locks | (accept ? rd_mask : '0)) & ~clr_mask;
      count <= count_next;
      if (accept && bus.instr_in_i.blocking)
        blk_pend <= 1'b1;
      else if (bus.done_valid_i && count_next == '0)
        blk_pend <= 1'b0;
      if (accept) begin
        out_q     <= bus.instr_in_i;
        out_valid <= 1'b1;
      end else if (bus.instr_out_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.instr_in_ready_o  = ready;
  assign bus.instr_out_o       = out_q;
  assign bus.instr_out_valid_o = out_valid;
  assign bus.locked_regs_o     = locks;
  assign bus.outstanding_o     = count;
endmodule

// File: tb/tb_rv64g_instr_launcher.sv
// Bench for rv64g_instr_launcher: directed scenarios plus a random phase, checked
// against a register-set/count model and an issue-order scoreboard.
module tb_rv64g_instr_launcher;
  import rv64g_pkg::*;

  localparam int W       = $bits(decoded_instr_t);
  localparam int MAX_OUT = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv64g_instr_launcher_if bus ();

  rv64g_instr_launcher dut (
    .clk_i  (clk),
    .arst_i (rst),
    .bus    (bus.slave)
  );

  int passed = 0;
  int total  = 0;

  logic [W-1:0] exp_q[$];
  int           inflight[$];
  bit [63:0]    m_locks = '0;
  int           m_cnt   = 0;
  bit           m_blk   = 1'b0;
  bit           m_full  = 1'b0;
  bit           m_acc   = 1'b0;
  logic         last_ready;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_ready();
    bit [63:0] rdm;
    rdm = (bus.instr_in_i.rd != 0) ? (64'd1 << bus.instr_in_i.rd) : 64'd0;
    return !rst && (!m_full || bus.instr_out_ready_i)
        && (((bus.instr_in_i.reg_req | rdm) & m_locks) == 0)
        && (m_cnt < MAX_OUT) && !m_blk
        && (!bus.instr_in_i.blocking || m_cnt == 0);
  endfunction

  task automatic model_step(input bit rdy);
    m_acc = bus.instr_in_valid_i && rdy;
    if (m_acc) begin
      exp_q.push_back(bus.instr_in_i);
      inflight.push_back(int'(bus.instr_in_i.rd));
      if (bus.instr_in_i.rd != 0) m_locks[bus.instr_in_i.rd] = 1'b1;
      if (bus.instr_in_i.blocking) m_blk = 1'b1;
    end
    if (bus.done_valid_i) begin
      if (bus.done_rd_i != 0) m_locks[bus.done_rd_i] = 1'b0;
      for (int i = 0; i < inflight.size(); i++)
        if (inflight[i] == int'(bus.done_rd_i)) begin
          inflight.delete(i);
          break;
        end
    end
    if (m_acc && !bus.done_valid_i) m_cnt++;
    else if (!m_acc && bus.done_valid_i && m_cnt > 0) m_cnt--;
    if (bus.done_valid_i && m_cnt == 0 && !(m_acc && bus.instr_in_i.blocking)) m_blk = 1'b0;
    m_full = m_acc ? 1'b1 : (bus.instr_out_ready_i ? 1'b0 : m_full);
  endtask

  task automatic model_reset();
    exp_q.delete();
    inflight.delete();
    m_locks = '0;
    m_cnt   = 0;
    m_blk   = 1'b0;
    m_full  = 1'b0;
    m_acc   = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit rdy;
    @(negedge clk);
    rdy = model_ready();
    last_ready = bus.instr_in_ready_o;
    chk("in_ready", 128'(bus.instr_in_ready_o), 128'(rdy));
    chk("locked_regs", 128'(bus.locked_regs_o), 128'(m_locks));
    chk("outstanding", 128'(bus.outstanding_o), 128'(m_cnt));
    @(posedge clk);
    model_step(rdy);
    #1;
  endtask

  task automatic present(input int rd, input logic [63:0] req, input bit blk);
    decoded_instr_t d;
    d.raw      = $urandom;
    d.rd       = 6'(rd);
    d.reg_req  = req;
    d.blocking = blk;
    bus.instr_in_i       = d;
    bus.instr_in_valid_i = 1'b1;
  endtask

  task automatic done(input int rd);
    bus.done_valid_i = 1'b1;
    bus.done_rd_i    = 6'(rd);
    cycle();
    bus.done_valid_i = 1'b0;
  endtask

  task automatic drain();
    bus.instr_in_valid_i  = 1'b0;
    bus.instr_out_ready_i = 1'b1;
    for (int n = 0; n < 20 && inflight.size() != 0; n++) done(inflight[0]);
    cycle();
    chk("drain_outstanding", 128'(bus.outstanding_o), 128'(0));
  endtask

  function automatic int rand_reg();
    int r;
    r = $urandom_range(0, 11);
    if ($urandom_range(0, 3) == 0) r += 32;
    return r;
  endfunction

  // Scoreboard monitor: every presented output must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 128'(bus.instr_out_valid_o), 128'(exp_q.size() != 0));
      if (bus.instr_out_valid_o && exp_q.size() != 0) begin
        chk("instr_out", 128'(bus.instr_out_o), 128'(exp_q[0]));
        if (bus.instr_out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_in_i        = '0;
    bus.instr_in_valid_i  = 1'b0;
    bus.instr_out_ready_i = 1'b1;
    bus.done_valid_i      = 1'b0;
    bus.done_rd_i         = '0;
    #1;
    cycle();
    cycle();
    chk("reset_out_valid", 128'(bus.instr_out_valid_o), 128'(0));
    chk("reset_instr_out", 128'(bus.instr_out_o), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Independent ADDI stream to x1, x2, x3.
    for (int i = 1; i <= 3; i++) begin
      present(i, 64'h1, 1'b0);
      cycle();
      chk("stream_ready", 128'(last_ready), 128'(1));
    end
    bus.instr_in_valid_i = 1'b0;
    chk("stream_locks", 128'(bus.locked_regs_o), 128'(64'h0E));
    chk("stream_count", 128'(bus.outstanding_o), 128'(3));
    drain();

    // RAW hazard on x5.
    present(5, 64'h1, 1'b0);
    cycle();
    present(6, 64'd1 << 5, 1'b0);
    repeat (3) begin
      cycle();
      chk("raw_wait", 128'(last_ready), 128'(0));
    end
    done(5);
    chk("raw_no_bypass", 128'(last_ready), 128'(0));
    cycle();
    chk("raw_accept", 128'(last_ready), 128'(1));
    bus.instr_in_valid_i = 1'b0;
    chk("raw_launch", 128'(bus.instr_out_valid_o), 128'(1));
    drain();

    // Outstanding budget.
    for (int i = 1; i <= 7; i++) begin
      present(i, 64'h0, 1'b0);
      cycle();
    end
    present(8, 64'h0, 1'b0);
    cycle();
    chk("budget_full", 128'(last_ready), 128'(0));
    chk("budget_count", 128'(bus.outstanding_o), 128'(7));
    done(1);
    chk("budget_still_full", 128'(last_ready), 128'(0));
    cycle();
    chk("budget_accept", 128'(last_ready), 128'(1));
    drain();

    // Blocking FENCE.
    present(1, 64'h0, 1'b0); cycle();
    present(2, 64'h0, 1'b0); cycle();
    present(0, 64'h0, 1'b1);
    cycle();
    chk("fence_wait", 128'(last_ready), 128'(0));
    done(1);
    chk("fence_wait1", 128'(last_ready), 128'(0));
    done(2);
    chk("fence_wait2", 128'(last_ready), 128'(0));
    cycle();
    chk("fence_accept", 128'(last_ready), 128'(1));
    present(3, 64'h0, 1'b0);
    cycle();
    chk("after_fence_wait", 128'(last_ready), 128'(0));
    done(0);
    chk("after_fence_wait2", 128'(last_ready), 128'(0));
    cycle();
    chk("after_fence_accept", 128'(last_ready), 128'(1));
    drain();

    // Backpressure, x0 and f0.
    bus.instr_out_ready_i = 1'b0;
    present(32, 64'h0, 1'b0);
    cycle();
    present(0, 64'h1, 1'b0);
    repeat (3) begin
      cycle();
      chk("bp_ready", 128'(last_ready), 128'(0));
    end
    chk("f0_locked", 128'(bus.locked_regs_o[32]), 128'(1));
    bus.instr_out_ready_i = 1'b1;
    cycle();
    chk("bp_reload", 128'(last_ready), 128'(1));
    bus.instr_in_valid_i = 1'b0;
    chk("x0_no_lock", 128'(bus.locked_regs_o), 128'(64'd1 << 32));
    drain();

    // Accept and done together, then a done with nothing in flight.
    present(1, 64'h0, 1'b0); cycle();
    present(2, 64'h0, 1'b0);
    done(1);
    chk("acc_done_ready", 128'(last_ready), 128'(1));
    chk("acc_done_count", 128'(bus.outstanding_o), 128'(1));
    drain();
    done(7);
    chk("underflow_count", 128'(bus.outstanding_o), 128'(0));

    // Asynchronous reset mid-stream.
    bus.instr_out_ready_i = 1'b0;
    present(1, 64'h0, 1'b0);
    cycle();
    bus.instr_in_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(bus.instr_out_valid_o), 128'(0));
    chk("arst_instr_out", 128'(bus.instr_out_o), 128'(0));
    chk("arst_locks", 128'(bus.locked_regs_o), 128'(0));
    chk("arst_count", 128'(bus.outstanding_o), 128'(0));
    chk("arst_ready", 128'(bus.instr_in_ready_o), 128'(0));
    model_reset();
    bus.instr_out_ready_i = 1'b1;
    cycle();
    @(posedge clk); #1;
    rst = 1'b0;
    done(1);
    chk("stale_done_count", 128'(bus.outstanding_o), 128'(0));

    // Random phase.
    bus.instr_in_valid_i = 1'b0;
    m_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.instr_in_valid_i || m_acc) begin
        if ($urandom_range(0, 3) != 0)
          present(rand_reg(), (64'd1 << rand_reg()) | (64'd1 << rand_reg()),
                  $urandom_range(0, 15) == 0);
        else
          bus.instr_in_valid_i = 1'b0;
      end
      bus.instr_out_ready_i = ($urandom_range(0, 3) != 0);
      if (inflight.size() != 0 && $urandom_range(0, 9) < 4) begin
        bus.done_valid_i = 1'b1;
        bus.done_rd_i    = 6'(inflight[$urandom_range(0, inflight.size() - 1)]);
      end else begin
        bus.done_valid_i = 1'b0;
      end
      cycle();
    end
    bus.done_valid_i = 1'b0;
    drain();
    cycle();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rv64g_instr_launcher.md
# rv64g_instr_launcher

Consumer end of the `decoded_instr_t` interface. It accepts decoded instructions from the decoder and holds each one until its source and destination registers are free of outstanding writes. It then issues the instruction through a one-entry output register to the execution units, which later retire it on a done port. Serialisation rules:
- a per-register lock scoreboard;
- an outstanding-instruction budget;
- the `blocking` flag.

## Interface
- `NUM_OUTSTANDING`, default `rv64g_pkg::NUM_OUTSTANDING` (7): maximum number of launched, not-yet-done instructions.
- `NUM_REGS`, default `rv64g_pkg::NUM_REGS` (64): scoreboard width. Indices 0..31 are GPRs, 32..63 are FPRs.
- `clk_i  input  1`: clock. All state updates on the rising edge.
- `arst_i  input  1`: asynchronous, active-high reset.
- `instr_in_i  input  decoded_instr_t`: instruction from the decoder.
- `instr_in_valid_i  input  1`: input valid.
- `instr_in_ready_o  output  1`: input ready.
- `instr_out_o  output  decoded_instr_t`: launched instruction.
- `instr_out_valid_o  output  1`: output valid.
- `instr_out_ready_i  input  1`: output ready from the execution units.
- `done_valid_i  input  1`: one launched instruction has completed.
- `done_rd_i  input  $clog2(NUM_REGS)`: `rd` of the completed instruction.
- `locked_regs_o  output  NUM_REGS`: current lock scoreboard.
- `outstanding_o  output  $clog2(NUM_OUTSTANDING+1)`: current in-flight count.

## Operation
- **State:**
  - `locks[NUM_REGS]`
  - `count`
  - `blk_pend` (a blocking instruction is in flight)
  - output register {`instr_out_o`, `instr_out_valid_o`}
- **Definitions:**
  - `rd_mask` = onehot(`instr_in_i.rd`), forced to 0 when `rd`==0 (x0 is never locked; index 32 = f0 is lockable).
  - `hazard` = |((`instr_in_i.reg_req` | `rd_mask`) & `locks`).
- **Ready:** `instr_in_ready_o` is high only when all of these hold:
  - `!arst_i`
  - (`!instr_out_valid_o` | `instr_out_ready_i`)
  - `!hazard`
  - `count` < `NUM_OUTSTANDING`
  - `!blk_pend`
  - (`!instr_in_i.blocking` | `count`==0)
- Ready may depend combinationally on `instr_in_i` and `instr_in_valid_i`.
- **Accept** = `instr_in_valid_i` & `instr_in_ready_o`. On accept:
  - the output register loads `instr_in_i`;
  - `instr_out_valid_o` is set;
  - `locks` |= `rd_mask`;
  - `count` is incremented;
  - `blk_pend` is set if `instr_in_i.blocking`.
- **Output drain:**
  - If the output handshake completes with no accept in the same cycle, `instr_out_valid_o` clears.
  - If an accept coincides with the output handshake, the register is reloaded (back-to-back issue).
  - While `instr_out_valid_o` is high and `instr_out_ready_i` is low, `instr_out_o` stays stable.
- **Done:** on `done_valid_i`:
  - `locks[done_rd_i]` is cleared (no effect for index 0);
  - `count` is decremented;
  - if `count` reaches 0, `blk_pend` clears.
- **Done with `count`==0:** protocol error. `count` stays 0 and there is no underflow. The lock clear still applies.
- **Accept and done in the same cycle:** `count` is unchanged. Lock set and lock clear apply independently. They cannot target the same index, because an accept requires its `rd` to be unlocked.
- **No bypass:** a done in cycle t is not visible to the hazard check until cycle t+1.
- **Blocking instructions:**
  - launch only with zero in flight;
  - once launched, no further accept until every outstanding instruction, including the blocking one, is done.

## Timing
- **Reset values:**
  - `instr_out_valid_o`=0
  - `instr_out_o`='0
  - `locks`=0 (`locked_regs_o`=0)
  - `outstanding_o`=0
  - `instr_in_ready_o`=0 while `arst_i` is high
- **Reset mid-operation:** asserting `arst_i` immediately drops the in-flight output and clears all locks and the count. Done pulses that arrive after reset for instructions launched before reset hit the `count`==0 rule.
- **Launch latency:** accept in cycle t → `instr_out_valid_o` high in cycle t+1.
- **Throughput:** one instruction per cycle for independent instructions when `instr_out_ready_i` is held high.
- **Dependency latency:** a dependent instruction's done in cycle t → earliest accept t+1 → `instr_out_valid_o` high in cycle t+2.
- **Outputs:** `locked_regs_o` and `outstanding_o` are registered state.

## Test plan
- **Reset then independent stream:** release reset, then send `ADDI` to x1, x2, x3 with `reg_req` limited to x0, `instr_out_ready_i`=1.
  - Ready is high every cycle and the outputs appear on cycles 1, 2, 3.
  - `locked_regs_o`=0x0E and `outstanding_o`=3.
- **RAW hazard:** launch `rd`=x5, then present an instruction with `reg_req` bit 5 set.
  - Ready stays 0 until `done_valid_i` with `done_rd_i`=5 in cycle t.
  - Accept happens in cycle t+1 and the output is valid in cycle t+2.
- **Outstanding budget:** launch 7 instructions to x1..x7 with no done.
  - 8th instruction (rd=x8): ready=0, `outstanding_o`=7.
  - One done (`done_rd_i`=1) → the 8th is accepted next cycle.
- **Blocking `FENCE`:** with 2 in flight, present `FENCE` (blocking=1).
  - Ready stays 0 until both are done, then `FENCE` is accepted.
  - The following `ADDI` waits until `FENCE` is done (`outstanding_o`=0).
- **Backpressure and x0/f0:** hold `instr_out_ready_i`=0.
  - `instr_out_o` is held stable and ready=0.
  - `rd`=x0 sets no lock; `rd`=32 sets `locked_regs_o[32]`.
- **Simultaneous events and async reset:**
  - Accept plus done in the same cycle → `outstanding_o` unchanged.
  - Done with count 0 → count stays 0.
  - Assert `arst_i` mid-stream → all outputs return to reset values without waiting for a clock edge.
